pwm_decoder: RTL and testbench

Servo-style PWM pulse-width decoder, the receive-side counterpart of the motor driver's PWM generator. It synchronizes an asynchronous `pwm_in`, measures each high pulse in `clk` ticks, and classifies the width into the team's 2-bit motor instruction code: `2'b10` back, `2'b11` stop, `2'b01` forward. It also provides a loss-of-signal failsafe that forces stop, and sits between an external PWM source and any block that consumes `instr`.

---
 rtl/pwm_decoder.sv | 151 +++++++++++++++
 tb/tb_pwm_decoder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_decoder.sv
// rtl/pwm_decoder.sv - servo PWM pulse-width decoder with loss-of-signal failsafe
// Measures each high pulse in clk ticks and maps it to the 2-bit motor instruction code.
module pwm_decoder #(
    parameter int CNT_W    = 12,
    parameter int MIN_W    = 100,
    parameter int BACK_MAX = 192,
    parameter int FWD_MIN  = 269,
    parameter int MAX_W    = 400,
    parameter int TIMEOUT  = 3600
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pwm_in,
    output logic [1:0]       instr,
    output logic [CNT_W-1:0] width,
    output logic             valid,
    output logic             err,
    output logic             timeout
);

    localparam logic [1:0] INSTR_BACK = 2'b10;
    localparam logic [1:0] INSTR_STOP = 2'b11;
    localparam logic [1:0] INSTR_FWD  = 2'b01;

    localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_W);
    localparam logic [CNT_W-1:0] BACK_C = CNT_W'(BACK_MAX);
    localparam logic [CNT_W-1:0] FWD_C  = CNT_W'(FWD_MIN);
    localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_W);
    localparam logic [CNT_W-1:0] TO_C   = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_ARM  = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       sync_q;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic [1:0]       instr_q, instr_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             timeout_q, timeout_d;
    logic             s2, s3, rise, fall;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (&x) ? x : x + ONE_C;
    endfunction

    function automatic logic [1:0] decode(input logic [CNT_W-1:0] w);
        if (w <= BACK_C)
            return INSTR_BACK;
        else if (w >= FWD_C)
            return INSTR_FWD;
        else
            return INSTR_STOP;
    endfunction

    assign s2   = sync_q[1];
    assign s3   = sync_q[2];
    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

    // Synchronizer resets high so a pulse already in progress at reset release is skipped by ARM.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q    <= 3'b111;
            state_q   <= ST_ARM;
            hcnt_q    <= '0;
            pcnt_q    <= '0;
            width_q   <= '0;
            instr_q   <= INSTR_STOP;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            timeout_q <= 1'b1;
        end else begin
            sync_q    <= {sync_q[1:0], pwm_in};
            state_q   <= state_d;
            hcnt_q    <= hcnt_d;
            pcnt_q    <= pcnt_d;
            width_q   <= width_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        hcnt_d    = hcnt_q;
        pcnt_d    = pcnt_q;
        width_d   = width_q;
        instr_d   = instr_q;
        timeout_d = timeout_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            ST_ARM: begin
                if (!s2)
                    state_d = ST_LOW;
            end
            ST_LOW: begin
                if (rise) begin
                    hcnt_d  = ONE_C;
                    pcnt_d  = ONE_C;
                    state_d = ST_HIGH;
                end else begin
                    pcnt_d = sat_inc(pcnt_q);
                    if (pcnt_q == TO_C) begin
                        timeout_d = 1'b1;
                        instr_d   = INSTR_STOP;
                    end
                end
            end
            ST_HIGH: begin
                pcnt_d = sat_inc(pcnt_q);
                if (fall) begin
                    width_d = hcnt_q;
                    state_d = ST_LOW;
                    if (hcnt_q >= MIN_C && hcnt_q <= MAX_C) begin
                        valid_d   = 1'b1;
                        instr_d   = decode(hcnt_q);
                        timeout_d = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    hcnt_d = sat_inc(hcnt_q);
                    // A stuck-high input is abandoned rather than reported on its eventual fall.
                    if (pcnt_q == TO_C) begin
                        timeout_d = 1'b1;
                        instr_d   = INSTR_STOP;
                        state_d   = ST_ARM;
                    end
                end
            end
            default: state_d = ST_ARM;
        endcase
    end

    assign instr   = instr_q;
    assign width   = width_q;
    assign valid   = valid_q;
    assign err     = err_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_pwm_decoder.sv
// tb/tb_pwm_decoder.sv - directed self-checking bench for pwm_decoder
module tb_pwm_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        pwm_in;
    logic [1:0]  instr;
    logic [11:0] width;
    logic        valid;
    logic        err;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    pwm_decoder dut (
        .clk     (clk),
        .reset   (reset),
        .pwm_in  (pwm_in),
        .instr   (instr),
        .width   (width),
        .valid   (valid),
        .err     (err),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          vcnt = 0, ecnt = 0, both = 0;
    int          vcyc = 0, ecyc = 0, to_cyc = -1;
    logic        to_prev = 1'b1;
    logic [11:0] vwidth = '0;
    logic [1:0]  vinstr = '0;

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            vcnt++;
            vcyc   = cyc;
            vwidth = width;
            vinstr = instr;
        end
        if (err === 1'b1) begin
            ecnt++;
            ecyc = cyc;
        end
        if (valid === 1'b1 && err === 1'b1) both++;
        if (timeout === 1'b1 && to_prev !== 1'b1) to_cyc = cyc;
        to_prev = timeout;
    end

    int start_cyc, fall_cyc;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int hi, input int lo);
        pwm_in    = 1'b1;
        start_cyc = cyc;
        step(hi);
        pwm_in    = 1'b0;
        fall_cyc  = cyc;
        step(lo);
    endtask

    task automatic check_reset_values(input string tag);
        checks++; if (instr !== 2'b11) begin errors++; $display("FAIL %s_instr got %b expected 11", tag, instr); end
        checks++; if (width !== 12'd0) begin errors++; $display("FAIL %s_width got %0d expected 0", tag, width); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL %s_valid got %b expected 0", tag, valid); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL %s_err got %b expected 0", tag, err); end
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL %s_timeout got %b expected 1", tag, timeout); end
    endtask

    task automatic test_reset;
        reset  = 1'b1;
        pwm_in = 1'b1;
        step(5);
        check_reset_values("reset");
        reset = 1'b0;
        step(50);
        pwm_in = 1'b0;
        step(200);
        checks++; if (vcnt != 0 || ecnt != 0) begin errors++; $display("FAIL partial_pulse got valid=%0d err=%0d expected 0 0", vcnt, ecnt); end
        pulse(230, 500);
        checks++; if (vcnt != 1) begin errors++; $display("FAIL first_valid_count got %0d expected 1", vcnt); end
        checks++; if (vwidth !== 12'd230) begin errors++; $display("FAIL first_width got %0d expected 230", vwidth); end
        checks++; if (vinstr !== 2'b11) begin errors++; $display("FAIL first_instr got %b expected 11", vinstr); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL first_timeout got %b expected 0", timeout); end
        checks++; if (vcyc != fall_cyc + 3) begin errors++; $display("FAIL first_latency got %0d expected %0d", vcyc, fall_cyc + 3); end
    endtask

    task automatic test_code_sweep;
        int         w[3]  = '{154, 230, 307};
        logic [1:0] ex[3] = '{2'b10, 2'b11, 2'b01};
        for (int i = 0; i < 3; i++) begin
            int v0 = vcnt;
            int e0 = ecnt;
            pulse(w[i], 3072 - w[i]);
            checks++; if (vcnt != v0 + 1 || ecnt != e0) begin errors++; $display("FAIL sweep%0d_count got valid=%0d err=%0d expected %0d %0d", i, vcnt - v0, ecnt - e0, 1, 0); end
            checks++; if (vwidth !== 12'(w[i])) begin errors++; $display("FAIL sweep%0d_width got %0d expected %0d", i, vwidth, w[i]); end
            checks++; if (vinstr !== ex[i]) begin errors++; $display("FAIL sweep%0d_instr got %b expected %b", i, vinstr, ex[i]); end
            checks++; if (vcyc != fall_cyc + 3) begin errors++; $display("FAIL sweep%0d_latency got %0d expected %0d", i, vcyc, fall_cyc + 3); end
        end
    endtask

    task automatic test_thresholds;
        int         w[9]  = '{1, 99, 100, 192, 193, 268, 269, 400, 401};
        bit         be[9] = '{1, 1, 0, 0, 0, 0, 0, 0, 1};
        logic [1:0] ex[9] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11, 2'b01, 2'b01, 2'b01};
        for (int i = 0; i < 9; i++) begin
            int v0 = vcnt;
            int e0 = ecnt;
            pulse(w[i], 600);
            if (be[i]) begin
                checks++; if (ecnt != e0 + 1 || vcnt != v0) begin errors++; $display("FAIL thr%0d_errcount got valid=%0d err=%0d expected 0 1", w[i], vcnt - v0, ecnt - e0); end
                checks++; if (ecyc != fall_cyc + 3) begin errors++; $display("FAIL thr%0d_latency got %0d expected %0d", w[i], ecyc, fall_cyc + 3); end
            end else begin
                checks++; if (vcnt != v0 + 1 || ecnt != e0) begin errors++; $display("FAIL thr%0d_validcount got valid=%0d err=%0d expected 1 0", w[i], vcnt - v0, ecnt - e0); end
            end
            checks++; if (width !== 12'(w[i])) begin errors++; $display("FAIL thr%0d_width got %0d expected %0d", w[i], width, w[i]); end
            checks++; if (instr !== ex[i]) begin errors++; $display("FAIL thr%0d_instr got %b expected %b", w[i], instr, ex[i]); end
        end
    endtask

    task automatic test_loss_of_signal;
        int v0;
        pulse(307, 600);
        to_cyc = -1;
        pulse(307, 3700);
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL los_timeout got %b expected 1", timeout); end
        checks++; if (instr !== 2'b11) begin errors++; $display("FAIL los_instr got %b expected 11", instr); end
        checks++; if (to_cyc != start_cyc + 3603) begin errors++; $display("FAIL los_time got %0d expected %0d", to_cyc, start_cyc + 3603); end
        v0 = vcnt;
        pulse(307, 600);
        checks++; if (vcnt != v0 + 1) begin errors++; $display("FAIL los_recover_count got %0d expected 1", vcnt - v0); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL los_recover_timeout got %b expected 0", timeout); end
        checks++; if (instr !== 2'b01) begin errors++; $display("FAIL los_recover_instr got %b expected 01", instr); end
    endtask

    task automatic test_stuck_high;
        int v0 = vcnt;
        int e0 = ecnt;
        to_cyc    = -1;
        pwm_in    = 1'b1;
        start_cyc = cyc;
        step(4000);
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL stuck_timeout got %b expected 1", timeout); end
        checks++; if (instr !== 2'b11) begin errors++; $display("FAIL stuck_instr got %b expected 11", instr); end
        checks++; if (to_cyc != start_cyc + 3603) begin errors++; $display("FAIL stuck_time got %0d expected %0d", to_cyc, start_cyc + 3603); end
        pwm_in = 1'b0;
        step(600);
        checks++; if (vcnt != v0 || ecnt != e0) begin errors++; $display("FAIL stuck_report got valid=%0d err=%0d expected 0 0", vcnt - v0, ecnt - e0); end
        pulse(154, 600);
        checks++; if (vcnt != v0 + 1) begin errors++; $display("FAIL stuck_next_count got %0d expected 1", vcnt - v0); end
        checks++; if (vwidth !== 12'd154) begin errors++; $display("FAIL stuck_next_width got %0d expected 154", vwidth); end
        checks++; if (vinstr !== 2'b10) begin errors++; $display("FAIL stuck_next_instr got %b expected 10", vinstr); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL stuck_next_timeout got %b expected 0", timeout); end
    endtask

    task automatic test_reset_mid_pulse;
        int v0 = vcnt;
        int e0 = ecnt;
        pwm_in = 1'b1;
        step(100);
        reset = 1'b1;
        step(2);
        check_reset_values("midreset");
        reset = 1'b0;
        step(205);
        pwm_in = 1'b0;
        step(600);
        checks++; if (vcnt != v0 || ecnt != e0) begin errors++; $display("FAIL midreset_report got valid=%0d err=%0d expected 0 0", vcnt - v0, ecnt - e0); end
        pulse(230, 600);
        checks++; if (vcnt != v0 + 1 || vwidth !== 12'd230) begin errors++; $display("FAIL midreset_next got count=%0d width=%0d expected 1 230", vcnt - v0, vwidth); end
    endtask

    initial begin
        reset  = 1'b1;
        pwm_in = 1'b1;
        test_reset();
        test_code_sweep();
        test_thresholds();
        test_loss_of_signal();
        test_stuck_high();
        test_reset_mid_pulse();
        checks++; if (both != 0) begin errors++; $display("FAIL valid_err_overlap got %0d expected 0", both); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
